// File: rtl/uart_wb_ctrl.sv
// uart_wb_ctrl: Wishbone master that moves TX/RX bytes and divider updates
// to a memory-mapped UART slave, polling its status register in between.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   INIT    | write DIV_INIT to the control register once after reset
//   IDLE    | bus gap cycle; choose divider write or status poll
//   POLL    | read status register, pick RX or TX service on ack
//   RD_DATA | read one byte from the RX data register
//   WR_DATA | write one TX byte to the data register
//   WR_DIV  | write the latched divider to the control register
module uart_wb_ctrl #(
  parameter int DW        = 16,
  parameter int DIV_WIDTH = 8,
  parameter int DIV_INIT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_stb,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ovf,
  input  logic                 ovf_clr,
  output logic [1:0]           wb_addr,
  output logic [DW-1:0]        wb_wdata,
  input  logic [DW-1:0]        wb_rdata,
  output logic                 wb_we,
  output logic                 wb_cyc,
  input  logic                 wb_ack
);

  typedef enum logic [2:0] {INIT, IDLE, POLL, RD_DATA, WR_DATA, WR_DIV} state_t;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam int B_RXE = DW - 1;
  localparam int B_OVF = DW - 2;
  localparam int B_TXE = DW - 3;
  localparam int B_TXF = DW - 4;

  state_t               r_state;
  logic                 r_cyc;
  logic                 r_we;
  logic [1:0]           r_addr;
  logic [DW-1:0]        r_wdata;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_ovf;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_pend;
  logic                 r_stb_seen;
  logic                 r_prefer_tx;

  logic w_rx_cand;
  logic w_tx_cand;
  logic w_pick_tx;
  logic w_unused;

  // Candidates are evaluated against the status word on the bus during the POLL ack.
  assign w_rx_cand = ~wb_rdata[B_RXE] & ~r_rx_valid;
  assign w_tx_cand = tx_valid & ~wb_rdata[B_TXF];
  assign w_pick_tx = w_tx_cand & (~w_rx_cand | r_prefer_tx);
  assign w_unused  = ^{wb_rdata[B_TXE], wb_rdata[DW-5:8]};

  assign wb_cyc   = r_cyc;
  assign wb_we    = r_we;
  assign wb_addr  = r_addr;
  assign wb_wdata = r_wdata;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_ovf   = r_rx_ovf;
  // The TX handshake completes exactly when the slave accepts the data write.
  assign tx_ready = (r_state == WR_DATA) & r_cyc & wb_ack;

  // Sequencer: bus transactions, RX/TX stream registers, divider request and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 2'd0;
      r_wdata     <= '0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_div       <= '0;
      r_pend      <= 1'b0;
      r_stb_seen  <= 1'b0;
      r_prefer_tx <= 1'b0;
    end else begin
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (ovf_clr) r_rx_ovf <= 1'b0;
      if (cfg_stb) begin
        r_div  <= cfg_div;
        r_pend <= 1'b1;
      end

      unique case (r_state)
        INIT: begin
          if (!r_cyc) begin
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= A_CTRL;
            r_wdata <= DW'(DIV_INIT);
          end else if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end
        end
        IDLE: begin
          r_cyc  <= 1'b1;
          r_addr <= A_CTRL;
          if (r_pend) begin
            r_we       <= 1'b1;
            r_wdata    <= DW'(r_div);
            // A strobe in this cycle updates r_div after the old value is captured.
            r_stb_seen <= cfg_stb;
            r_state    <= WR_DIV;
          end else begin
            r_we    <= 1'b0;
            r_state <= POLL;
          end
        end
        POLL: begin
          if (wb_ack) begin
            r_cyc <= 1'b0;
            if (wb_rdata[B_OVF]) r_rx_ovf <= 1'b1;
            if (w_pick_tx) begin
              r_prefer_tx <= 1'b0;
              r_state     <= WR_DATA;
            end else if (w_rx_cand) begin
              r_prefer_tx <= 1'b1;
              r_state     <= RD_DATA;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        RD_DATA: begin
          if (!r_cyc) begin
            r_cyc  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= A_DATA;
          end else if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
            if (!wb_rdata[B_RXE]) begin
              r_rx_data  <= wb_rdata[7:0];
              r_rx_valid <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (!r_cyc) begin
            r_cyc   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= A_DATA;
            r_wdata <= DW'(tx_data);
          end else if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end
        end
        WR_DIV: begin
          if (wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
            // Keep the request pending if a newer divider arrived after this write began.
            if (!cfg_stb && !r_stb_seen) r_pend <= 1'b0;
          end else if (cfg_stb) begin
            r_stb_seen <= 1'b1;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// tb_uart_wb_ctrl: directed bench with a 2-cycle-ack Wishbone slave model.
module tb_uart_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cfg_div = 8'd0;
  logic        cfg_stb = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_ovf;
  logic        ovf_clr = 1'b0;
  logic [1:0]  wb_addr;
  logic [15:0] wb_wdata;
  logic [15:0] wb_rdata = 16'd0;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_wb_ctrl #(.DW(16), .DIV_WIDTH(8), .DIV_INIT(8'h1A)) dut (
    .clk(clk), .rst(rst),
    .cfg_div(cfg_div), .cfg_stb(cfg_stb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_ovf(rx_ovf), .ovf_clr(ovf_clr),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [15:0] d;
  } txn_t;

  txn_t        q[$];
  int          s_cnt = 0;
  logic [15:0] s_stat = 16'hA000;  // rx_empty, overflow, tx_empty, tx_full in [15:12]
  logic [15:0] s_data = 16'h0000;

  // Slave model: ack two cycles after wb_cyc rises, log each transaction at ack.
  always @(negedge clk) begin
    if (wb_cyc && !wb_ack) begin
      s_cnt = s_cnt + 1;
      if (s_cnt == 2) begin
        wb_ack   = 1'b1;
        wb_rdata = (wb_addr == 2'd1) ? s_stat : s_data;
        q.push_back('{wb_addr, wb_we, wb_wdata});
      end
    end else begin
      wb_ack = 1'b0;
      s_cnt  = 0;
    end
  end

  int          n_txr = 0;
  int          viol = 0;
  logic        p_ack = 1'b0;
  logic        p_cyc = 1'b0;
  logic [1:0]  p_a = 2'd0;
  logic        p_we = 1'b0;
  logic [15:0] p_d = 16'd0;

  // Protocol monitor: stable request during a cycle, gap after ack, tx_ready only with ack.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (tx_ready) begin
        n_txr = n_txr + 1;
        if (!wb_ack) viol = viol + 1;
      end
      if (p_ack && wb_cyc) viol = viol + 1;
      if (wb_cyc && p_cyc && (wb_addr != p_a || wb_we != p_we || wb_wdata != p_d)) viol = viol + 1;
    end
    p_ack = wb_ack;
    p_cyc = wb_cyc;
    p_a   = wb_addr;
    p_we  = wb_we;
    p_d   = wb_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic int cnt_ops(input logic [1:0] a, input logic we);
    int n = 0;
    foreach (q[i]) if (q[i].a == a && q[i].we == we) n++;
    return n;
  endfunction

  function automatic logic [31:0] first_d(input logic [1:0] a, input logic we);
    foreach (q[i]) if (q[i].a == a && q[i].we == we) return {16'h0, q[i].d};
    return 32'hDEADBEEF;
  endfunction

  initial begin
    int n0;
    int k;
    logic [3:0] seq;
    int gaps_ok;
    int polls;

    // Reset state
    tick();
    tick();
    check_val("rst_cyc", wb_cyc, 0);
    check_val("rst_we", wb_we, 0);
    check_val("rst_addr", wb_addr, 0);
    check_val("rst_wdata", wb_wdata, 0);
    check_val("rst_tx_ready", tx_ready, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_rx_ovf", rx_ovf, 0);

    // First transaction: divider init write right after reset release
    rst = 1'b0;
    tick();
    check_val("init_cyc", wb_cyc, 1);
    check_val("init_we", wb_we, 1);
    check_val("init_addr", wb_addr, 1);
    check_val("init_wdata", wb_wdata, 16'h001A);
    for (int i = 0; i < 50 && q.size() < 2; i++) tick();
    check_val("init_txn_cnt_to", q.size() >= 2, 1);
    if (q.size() >= 2) begin
      check_val("init_txn", {q[0].a, q[0].we, q[0].d}, {2'd1, 1'b1, 16'h001A});
      check_val("first_poll", {q[1].a, q[1].we}, {2'd1, 1'b0});
    end

    // RX byte with consumer stalled
    s_data = 16'h0055;
    s_stat = 16'h2000;
    for (int i = 0; i < 100 && !rx_valid; i++) tick();
    check_val("rx_valid_to", rx_valid, 1);
    check_val("rx_data", rx_data, 8'h55);
    q.delete();
    for (int i = 0; i < 30; i++) tick();
    check_val("rx_stall_no_rd", cnt_ops(2'd0, 1'b0), 0);
    check_val("rx_stall_polls", cnt_ops(2'd1, 1'b0) > 0, 1);
    check_val("rx_valid_held", rx_valid, 1);
    s_stat = 16'hA000;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_val("rx_valid_clr", rx_valid, 0);

    // TX byte accepted
    q.delete();
    n0 = n_txr;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && n_txr == n0; i++) tick();
    check_val("tx_ready_to", n_txr != n0, 1);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_val("tx_ready_pulses", n_txr - n0, 1);
    check_val("tx_wr_cnt", cnt_ops(2'd0, 1'b1), 1);
    check_val("tx_wdata", first_d(2'd0, 1'b1), 32'h00A5);

    // TX blocked by tx_full
    s_stat = 16'hB000;
    q.delete();
    n0 = n_txr;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check_val("txfull_no_wr", cnt_ops(2'd0, 1'b1), 0);
    check_val("txfull_no_ready", n_txr - n0, 0);
    tx_valid = 1'b0;
    s_stat = 16'hA000;
    for (int i = 0; i < 10; i++) tick();

    // RX and TX both pending: alternate service, one poll between
    q.delete();
    n0 = n_txr;
    rx_ready = 1'b1;
    s_data = 16'h0011;
    s_stat = 16'h2000;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && (cnt_ops(2'd0, 1'b0) + cnt_ops(2'd0, 1'b1)) < 4; i++) tick();
    check_val("rr_ops_to", (cnt_ops(2'd0, 1'b0) + cnt_ops(2'd0, 1'b1)) >= 4, 1);
    tick();
    tx_valid = 1'b0;
    s_stat = 16'hA000;
    for (int i = 0; i < 10; i++) tick();
    rx_ready = 1'b0;
    k = 0;
    seq = 4'b0000;
    gaps_ok = 0;
    polls = -1;
    foreach (q[i]) begin
      if (q[i].a == 2'd0 && k < 4) begin
        seq[3-k] = q[i].we;
        if (polls == 1) gaps_ok++;
        polls = 0;
        k++;
      end else if (q[i].a == 2'd1 && !q[i].we && polls >= 0) begin
        polls++;
      end
    end
    check_val("rr_order", seq, 4'b0101);
    check_val("rr_one_poll_gap", gaps_ok, 3);
    check_val("rr_tx_pulses", n_txr - n0, 2);
    check_val("rr_rx_data", rx_data, 8'h11);

    // Two divider strobes during one poll: single write of the last value
    for (int i = 0; i < 50 && !(wb_cyc && wb_addr == 2'd1 && !wb_we && !wb_ack); i++) tick();
    check_val("div_poll_to", wb_cyc && wb_addr == 2'd1 && !wb_we, 1);
    q.delete();
    cfg_div = 8'h10;
    cfg_stb = 1'b1;
    tick();
    cfg_div = 8'h20;
    tick();
    cfg_stb = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check_val("div_wr_cnt", cnt_ops(2'd1, 1'b1), 1);
    check_val("div_wdata", first_d(2'd1, 1'b1), 32'h0020);
    if (q.size() >= 2) check_val("div_after_poll", {q[1].a, q[1].we}, {2'd1, 1'b1});
    else check_val("div_txn_cnt", q.size(), 2);

    // Overflow: set, set wins over clear, clear alone
    s_stat = 16'hE000;
    for (int i = 0; i < 100 && !rx_ovf; i++) tick();
    check_val("ovf_set", rx_ovf, 1);
    for (int i = 0; i < 50 && !(wb_ack && wb_addr == 2'd1 && !wb_we); i++) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_set_wins", rx_ovf, 1);
    s_stat = 16'hA000;
    for (int i = 0; i < 50 && !(wb_ack && wb_addr == 2'd1 && !wb_we); i++) tick();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_val("ovf_clr", rx_ovf, 0);

    // Asynchronous reset mid-transaction
    for (int i = 0; i < 50 && !wb_cyc; i++) tick();
    check_val("arst_cyc_before", wb_cyc, 1);
    #1 rst = 1'b1;
    #1 check_val("arst_cyc_drop", wb_cyc, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_val("rerst_cyc", wb_cyc, 1);
    check_val("rerst_req", {wb_addr, wb_we, wb_wdata}, {2'd1, 1'b1, 16'h001A});
    for (int i = 0; i < 20; i++) tick();

    check_val("protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
